// File: rtl/mmu_stub_pkg.sv
// Shared types and constants for the multi-request MMU stub: queue entry layout,
// exception record, fault causes and the latency LFSR seed/taps.
package mmu_stub_pkg;

  localparam int unsigned VLEN    = 64;
  localparam int unsigned PLEN    = 56;
  localparam int unsigned PPNW    = 44;
  localparam int unsigned XLEN    = 64;
  // Per-entry timer width; the top's LatW must not exceed it.
  localparam int unsigned TIMER_W = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [XLEN-1:0] LOAD_PAGE_FAULT  = 64'd13;
  localparam logic [XLEN-1:0] STORE_PAGE_FAULT = 64'd15;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0]    vaddr;
    logic               is_store;
    logic [PLEN-1:0]    paddr;
    logic [TIMER_W-1:0] timer;
  } mq_entry_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/mmu_stub_lat_gen.sv
// Pseudo-random response latency: Galois LFSR stepped once per accepted request,
// reduced into [1, lat_max_i]. Only instantiated when MMU_STUB_MQ_RND_LAT_EN is defined.
module mmu_stub_lat_gen
  import mmu_stub_pkg::*;
#(
  parameter int unsigned LatW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            adv_i,
  input  logic            rnd_i,
  input  logic [LatW-1:0] lat_max_i,
  output logic [LatW-1:0] lat_o
);

  logic [15:0]      lfsr;
  logic [LatW+15:0] rem;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= LFSR_SEED;
    end else if (adv_i) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // lat_max_i is already clamped to >= 1, so the modulo never divides by zero.
  assign rem   = {{LatW{1'b0}}, lfsr} % {16'h0000, lat_max_i};
  assign lat_o = rnd_i ? LatW'(rem + (LatW+16)'(1)) : lat_max_i;

endmodule

// File: rtl/mmu_stub_mq.sv
// In-order multi-outstanding MMU translation emulator with per-request latency,
// physical offset and periodic page-fault injection. Random latency: MMU_STUB_MQ_RND_LAT_EN.
module mmu_stub_mq
  import mmu_stub_pkg::*;
#(
  parameter int unsigned Depth  = 4,
  parameter int unsigned LatW   = 16,
  parameter int unsigned ExPerW = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_en_i,
  input  logic [ExPerW-1:0] ex_period_i,
  input  logic [LatW-1:0]   req_rsp_lat_i,
  input  logic              req_rsp_rnd_i,
  input  logic [PLEN-1:0]   paddr_off_i,
  input  logic              en_ld_st_translation_i,
  input  logic              req_i,
  output logic              req_ready_o,
  input  logic [VLEN-1:0]   vaddr_i,
  input  logic              is_store_i,
  output logic              dtlb_hit_o,
  output logic [PPNW-1:0]   dtlb_ppn_o,
  output logic              valid_o,
  input  logic              rsp_ready_i,
  output logic [PLEN-1:0]   paddr_o,
  output exception_t        exception_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  mq_entry_t         q [Depth];
  mq_entry_t         head;
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CntW-1:0]   count;
  logic [ExPerW-1:0] ex_cnt;
  logic [ExPerW:0]   ex_nxt;
  logic [LatW-1:0]   lat_max, lat_l;
  logic              full, push, pop, head_rdy, ex_fault;

  assign full        = (count == CntW'(Depth));
  assign req_ready_o = en_ld_st_translation_i & ~full;
  assign push        = req_i & req_ready_o;
  assign head        = q[rd_ptr];
  assign head_rdy    = (count != '0) && (head.timer == '0);
  assign pop         = head_rdy & rsp_ready_i;
  assign lat_max     = (req_rsp_lat_i == '0) ? LatW'(1) : req_rsp_lat_i;

`ifdef MMU_STUB_MQ_RND_LAT_EN
  mmu_stub_lat_gen #(.LatW(LatW)) u_lat_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .adv_i     (push),
    .rnd_i     (req_rsp_rnd_i),
    .lat_max_i (lat_max),
    .lat_o     (lat_l)
  );
`else
  logic unused_rnd;
  assign unused_rnd = req_rsp_rnd_i;
  assign lat_l      = lat_max;
`endif

  assign ex_nxt   = {1'b0, ex_cnt} + {{ExPerW{1'b0}}, 1'b1};
  assign ex_fault = ex_en_i && (ex_period_i != '0) && (ex_nxt == {1'b0, ex_period_i});

  assign dtlb_hit_o = push;
  assign dtlb_ppn_o = {PPNW{push}};
  assign valid_o    = head_rdy;
  assign paddr_o    = head_rdy ? head.paddr : '0;

  always_comb begin
    exception_o = '0;
    if (head_rdy && ex_fault) begin
      exception_o.valid = 1'b1;
      exception_o.cause = head.is_store ? STORE_PAGE_FAULT : LOAD_PAGE_FAULT;
      exception_o.tval  = XLEN'(head.vaddr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ex_cnt <= '0;
      for (int i = 0; i < Depth; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (q[i].timer != '0) q[i].timer <= q[i].timer - TIMER_W'(1);
      end
      // The accept cycle counts as the first tick, so L=1 is visible right after the accept edge.
      if (push) begin
        q[wr_ptr].vaddr    <= vaddr_i;
        q[wr_ptr].is_store <= is_store_i;
        q[wr_ptr].paddr    <= vaddr_i[PLEN-1:0] + paddr_off_i;
        q[wr_ptr].timer    <= TIMER_W'(lat_l - LatW'(1));
        wr_ptr             <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
        if (ex_en_i) ex_cnt <= ex_fault ? '0 : ex_nxt[ExPerW-1:0];
      end
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

endmodule

// File: tb/tb_mmu_stub_mq.sv
// Self-checking bench for mmu_stub_mq: directed and random traffic against a
// queue-based reference model keyed on due cycles; honours MMU_STUB_MQ_RND_LAT_EN.
module tb_mmu_stub_mq;
  import mmu_stub_pkg::*;

  localparam int Depth  = 4;
  localparam int LatW   = 16;
  localparam int ExPerW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_en;
  logic [ExPerW-1:0] ex_period;
  logic [LatW-1:0]   lat;
  logic              rnd;
  logic [PLEN-1:0]   off;
  logic              en;
  logic              req;
  logic              req_ready;
  logic [VLEN-1:0]   vaddr;
  logic              is_store;
  logic              dtlb_hit;
  logic [PPNW-1:0]   dtlb_ppn;
  logic              valid;
  logic              rsp_ready;
  logic [PLEN-1:0]   paddr;
  exception_t        exc;

  mmu_stub_mq #(.Depth(Depth), .LatW(LatW), .ExPerW(ExPerW)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .ex_en_i                (ex_en),
    .ex_period_i            (ex_period),
    .req_rsp_lat_i          (lat),
    .req_rsp_rnd_i          (rnd),
    .paddr_off_i            (off),
    .en_ld_st_translation_i (en),
    .req_i                  (req),
    .req_ready_o            (req_ready),
    .vaddr_i                (vaddr),
    .is_store_i             (is_store),
    .dtlb_hit_o             (dtlb_hit),
    .dtlb_ppn_o             (dtlb_ppn),
    .valid_o                (valid),
    .rsp_ready_i            (rsp_ready),
    .paddr_o                (paddr),
    .exception_o            (exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VLEN-1:0] vaddr;
    logic            is_store;
    logic [PLEN-1:0] paddr;
    int              acc;
    int              due;
    bit              seen;
  } exp_t;

  exp_t        mq[$];
  int          cyc, checks, passed, m_cnt, lat_hi, n_rsp, n_fault;
  logic [15:0] m_lfsr;
  logic [VLEN-1:0] rv_addr [200];
  logic            rv_st   [200];

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  function automatic int model_lat();
    int mx, l;
    mx = (lat == 0) ? 1 : int'(lat);
    l  = mx;
`ifdef MMU_STUB_MQ_RND_LAT_EN
    if (rnd) l = (int'(m_lfsr) % mx) + 1;
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`endif
    return l;
  endfunction

  // Compare outputs for the current cycle, advance the model across the edge, then clock.
  task automatic step();
    bit   e_rdy, e_acc, e_val, fault;
    exp_t e;
    #2;
    e_rdy = en && (mq.size() < Depth);
    e_acc = req && e_rdy;
    e_val = (mq.size() > 0) && (cyc >= mq[0].due);
    fault = 1'b0;
    chk("req_ready", req_ready, e_rdy);
    chk("dtlb_hit", dtlb_hit, e_acc);
    chk("dtlb_ppn", dtlb_ppn, e_acc ? {PPNW{1'b1}} : '0);
    chk("valid", valid, e_val);
    if (e_val) begin
      fault = ex_en && (ex_period != 0) && ((m_cnt + 1) == int'(ex_period));
      chk("paddr", paddr, mq[0].paddr);
      chk("ex_valid", exc.valid, fault);
      chk("ex_cause", exc.cause, fault ? (mq[0].is_store ? 64'd15 : 64'd13) : 64'd0);
      chk("ex_tval", exc.tval, fault ? mq[0].vaddr : '0);
      if (!mq[0].seen) begin
        mq[0].seen = 1'b1;
        if (lat_hi > 0)
          chk("lat_range", ((cyc - mq[0].acc) >= 1) && ((cyc - mq[0].acc) <= lat_hi), 1'b1);
      end
    end else begin
      chk("paddr_idle", paddr, '0);
      chk("exc_idle", exc, '0);
    end
    if (e_val && rsp_ready) begin
      void'(mq.pop_front());
      n_rsp++;
      if (fault) n_fault++;
      if (ex_en) m_cnt = fault ? 0 : (m_cnt + 1) % 256;
    end
    if (e_acc) begin
      e.vaddr    = vaddr;
      e.is_store = is_store;
      e.paddr    = vaddr[PLEN-1:0] + off;
      e.acc      = cyc;
      e.due      = cyc + model_lat();
      e.seen     = 1'b0;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mq.delete();
    m_cnt  = 0;
    m_lfsr = 16'hACE1;
    cyc    = 0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; passed = 0; lat_hi = 0; n_rsp = 0; n_fault = 0;
    ex_en = 0; ex_period = 0; lat = 1; rnd = 0; off = '0; en = 1;
    req = 0; vaddr = '0; is_store = 0; rsp_ready = 1;
    do_reset();

    // Reset state and a single lat=1 request
    step();
    req = 1; vaddr = 64'h1000; step();
    idle(3);

    // Fill to Depth with lat=5; fifth attempt must be refused
    lat = 5;
    for (int i = 0; i < 5; i++) begin
      req = 1; vaddr = {$urandom, $urandom}; is_store = 1'($urandom); step();
    end
    idle(12);

    // Backpressure: 4 entries, consumer stalled for 10 cycles
    lat = 3; rsp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      req = 1; vaddr = 64'h2000 + 64'(i * 64); step();
    end
    idle(10);
    rsp_ready = 1;
    idle(6);

    // Periodic fault injection, mixed loads/stores
    ex_en = 1; ex_period = 3; lat = 2; n_fault = 0;
    for (int i = 0; i < 6; i++) begin
      req = 1; vaddr = 64'h3000 + 64'(i * 8); is_store = 1'(i % 2); step();
      req = 0; step();
    end
    idle(6);
    chk("fault_count", 32'(n_fault), 32'd2);
    ex_en = 0;

    // Offset add and wrap at PLEN
    lat = 1; off = 56'h0000_0080_0000_00;
    off = 56'h00_0000_8000_0000;
    req = 1; vaddr = 64'h1234; step();
    idle(2);
    off = 56'hFF_FFFF_FFFF_F000;
    req = 1; vaddr = 64'hABCD_0000_0000_2345; step();
    idle(2);
    off = '0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      req       = 1'($urandom);
      vaddr     = {$urandom, $urandom};
      is_store  = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      lat       = LatW'($urandom_range(0, 6));
      rnd       = 1'($urandom);
      ex_en     = ($urandom_range(0, 3) != 0);
      ex_period = ExPerW'($urandom_range(0, 5));
      off       = {24'($urandom), $urandom};
      step();
    end
    en = 1; rsp_ready = 1; ex_en = 0; rnd = 0; lat = 1;
    idle(30);

    // Random latency with max 7; replayed after reset to show reproducibility
    for (int i = 0; i < 200; i++) begin
      rv_addr[i] = {$urandom, $urandom};
      rv_st[i]   = 1'($urandom);
    end
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      rnd = 1; lat = 7; lat_hi = 7; rsp_ready = 1; en = 1;
      for (int i = 0; i < 200; i++) begin
        req = 1; vaddr = rv_addr[i]; is_store = rv_st[i]; step();
      end
      idle(40);
    end
    lat_hi = 0; rnd = 0;

    // Reset with three entries in flight
    lat = 10;
    for (int i = 0; i < 3; i++) begin
      req = 1; vaddr = 64'h5000 + 64'(i); step();
    end
    do_reset();
    idle(20);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
